// File: rtl/locking_rr_arbiter_pkg.sv
// Shared types and constants for the locking round-robin arbiter.
// The default payload type stands in for the line-buffer read request.
package ArbST;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int ARB_CNT_W = 16;

    typedef logic [31:0] arb_payload_t;

endpackage

// File: rtl/locking_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin / fixed-priority picker.
// Uses a double-width masked priority encoder.
module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 rr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_double;

    // The upper copy catches the wrap-around.
    // A cleared mask (rr=0) degrades to plain lowest-index priority.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = rr && (i > int'(ptr));
        end
        w_double = {req, req & w_mask};
        any      = |req;
        gnt_idx  = '0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (w_double[j]) begin
                gnt_idx = IW'(j % N);
            end
        end
    end

endmodule

// File: rtl/locking_rr_arbiter.sv
// N-input valid/ready arbiter with round-robin/fixed policy and multi-beat lock.
// Define ARB_PERF_EN to add saturating per-input message grant counters (io_grant_cnt).
module locking_rr_arbiter
    import ArbST::*;
#(
    parameter int  N       = 4,
    parameter type T       = arb_payload_t,
    parameter int  RR      = 1,
    parameter int  LOCK_EN = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         io_in_valid,
    output logic [N-1:0]         io_in_ready,
    input  T                     io_in [N],
    input  logic [N-1:0]         io_in_last,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output T                     io_out,
    output logic                 io_out_last,
    output logic [$clog2(N)-1:0] io_chosen
`ifdef ARB_PERF_EN
    ,
    output logic [ARB_CNT_W-1:0] io_grant_cnt [N]
`endif
);

    localparam int IW = $clog2(N);

    arb_state_e      r_state;
    arb_state_e      w_next_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_lock_idx;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [IW-1:0]   w_chosen;
    logic            w_out_valid;
    logic            w_fire;

    rr_priority_pick #(
        .N(N)
    ) u_pick (
        .req    (io_in_valid),
        .ptr    (r_ptr),
        .rr     (RR != 0),
        .gnt_idx(w_pick_idx),
        .any    (w_pick_any)
    );

    // While locked, the burst owner keeps the output even if it stalls.
    always_comb begin
        w_chosen    = w_pick_idx;
        w_out_valid = w_pick_any;
        if (r_state == ARB_LOCKED) begin
            w_chosen    = r_lock_idx;
            w_out_valid = io_in_valid[r_lock_idx];
        end
        if (reset) begin
            w_out_valid = 1'b0;
        end
        w_fire = w_out_valid && io_out_ready;
    end

    always_comb begin
        io_in_ready = '0;
        if (!reset && io_out_ready) begin
            io_in_ready[w_chosen] = 1'b1;
        end
        io_out_valid = w_out_valid;
        io_out       = io_in[w_chosen];
        io_out_last  = io_in_last[w_chosen];
        io_chosen    = w_chosen;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_fire && LOCK_EN != 0 && !io_out_last) begin
                    w_next_state = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (w_fire && io_out_last) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // ptr moves only when a whole message has been delivered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr      <= IW'(N - 1);
            r_lock_idx <= '0;
        end else if (w_fire) begin
            if (r_state == ARB_LOCKED) begin
                if (io_out_last) begin
                    r_ptr <= r_lock_idx;
                end
            end else if (io_out_last || LOCK_EN == 0) begin
                r_ptr <= w_chosen;
            end else begin
                r_lock_idx <= w_chosen;
            end
        end
    end

`ifdef ARB_PERF_EN
    logic [ARB_CNT_W-1:0] r_grant_cnt [N];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (w_fire && io_out_last && r_grant_cnt[w_chosen] != '1) begin
            r_grant_cnt[w_chosen] <= r_grant_cnt[w_chosen] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            io_grant_cnt[i] = r_grant_cnt[i];
        end
    end
`endif

endmodule
